mmio_responder: RTL and testbench
=================================

Name: mmio_responder

Overview:
- Bus responder on the core's memory port (address / write-enable / write-data / read-data). It splits the 12-bit address space into a RAM window and a 16-register I/O window.
- RAM accesses pass through to the RAM instance. I/O accesses are served locally by:
  - a display register that drives the segment_led NUM input;
  - debounced button inputs with press latches;
  - a prescaled timer with compare flag.
- Instantiated in the top level between the core and the RAM, replacing the direct core–RAM wiring.

Parameters:
- ADDR_W, 12, core/RAM address width.
- DATA_W, 16, data width.
- IO_BASE, 12'hF00, I/O window base; window is IO_BASE..IO_BASE+15 (address bits [11:4] == IO_BASE[11:4]).
- NBTN, 4, number of button inputs.
- DEBOUNCE_CYCLES, 50000, stable-input cycles required before a button level is accepted.
- PRESCALE, 50000, CLK cycles per timer tick (must be >= 1).

Ports:
- CLK  in  1  system clock; every register is updated on its rising edge.
- RST  in  1  reset, synchronous, active-high.
- CORE_ADDR  in  ADDR_W  address from the core.
- CORE_WREN  in  1  write enable from the core.
- CORE_DATA  in  DATA_W  write data from the core.
- CORE_Q  out  DATA_W  read data to the core.
- RAM_ADDR  out  ADDR_W  to RAM address input.
- RAM_WREN  out  1  to RAM write enable.
- RAM_DATA  out  DATA_W  to RAM data input.
- RAM_Q  in  DATA_W  RAM read data (RAM is clocked on ~CLK).
- BTN  in  NBTN  raw asynchronous button levels, active-high.
- DISP_NUM  out  16  value for segment_led NUM.

Behaviour:
- io_sel = (CORE_ADDR[11:4] == IO_BASE[11:4]); combinational.
- Passthrough signals, all combinational:
  - RAM_ADDR = CORE_ADDR.
  - RAM_DATA = CORE_DATA.
  - RAM_WREN = CORE_WREN & ~io_sel, so I/O writes never reach RAM.
- CORE_Q = io_sel ? io_rdata : RAM_Q; combinational.
  - io_rdata is a combinational mux of registers on CORE_ADDR[3:0].
  - This gives RAM and I/O reads identical latency: data is valid before the next rising CLK edge.
- I/O writes take effect at the rising CLK edge that ends the access cycle.
- Register map (offset from IO_BASE), zero-extended to 16 bits:
  - 0x0 DISP (RW): drives DISP_NUM directly.
  - 0x1 BTN_STATE (RO): debounced levels, bits [NBTN-1:0].
  - 0x2 BTN_EDGE (R/W1C): bit set on a debounced 0->1 transition.
  - 0x3 TIMER_CNT (RW).
  - 0x4 TIMER_CMP (RW).
  - 0x5 STATUS (R/W1C): bit0 = timer match flag.
  - 0x6..0xF: read 0, writes ignored.
- Reset (RST=1 at a rising edge), values after reset:
  - DISP = 0.
  - BTN_STATE = 0, BTN_EDGE = 0.
  - TIMER_CNT = 0, TIMER_CMP = 16'hFFFF.
  - STATUS = 0, prescaler = 0.
  - Synchronizers and debounce counters = 0.
  - DISP_NUM = 0.
- Reset mid-operation overrides any write in the same cycle. Passthrough paths are unaffected by reset.
- Debounce, per bit:
  - Two-flop synchronizer, then a stability counter.
  - When the synced level differs from the accepted state, the counter increments each cycle; when they are equal, the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES-1, the state takes the new level and the counter clears.
  - Total latency from a clean BTN step to BTN_STATE change = 2 + DEBOUNCE_CYCLES cycles.
- BTN_EDGE:
  - Set on a debounced rise.
  - A write of 1 clears that bit.
  - A simultaneous set and clear leaves the bit set.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick = 1 for the single cycle in which prescaler == PRESCALE-1.
- Timer, on tick:
  - If TIMER_CNT == TIMER_CMP: TIMER_CNT <= 0 and STATUS[0] <= 1.
  - Else: TIMER_CNT <= TIMER_CNT + 1, 16-bit, wrapping at 16'hFFFF.
  - TIMER_CMP = 0 sets the flag on every tick, with TIMER_CNT held at 0.
- A core write to TIMER_CNT in a tick cycle: the write wins and no match is evaluated that cycle.
- STATUS[0] set and W1C in the same cycle: set wins.
- A write to TIMER_CMP does not reset the prescaler.

Decomposition:
- Shared package mmio_pkg holds:
  - register offset constants: OFF_DISP, OFF_BTN_STATE, OFF_BTN_EDGE, OFF_TIMER_CNT, OFF_TIMER_CMP, OFF_STATUS;
  - IO_BASE default;
  - the STATUS bit index.
- Sub-module btn_debounce (one bit: CLK, RST, IN, STATE, RISE; parameter DEBOUNCE_CYCLES) is instantiated NBTN times.

Test Plan:
- Reset, then write 16'h1234 to 0xF00 and read 0xF00 -> DISP_NUM = 16'h1234 after the write edge; CORE_Q = 16'h1234; RAM_WREN stays 0 throughout.
- Write 16'hBEEF to 0x010, then read 0x010 -> RAM_WREN = 1 in the write cycle only; CORE_Q = 16'hBEEF. Read 0xF0A -> CORE_Q = 0.
- DEBOUNCE_CYCLES = 4: BTN[1] glitch high for 3 cycles -> BTN_STATE stays 0. Hold high -> BTN_STATE = 2 and BTN_EDGE = 2 exactly 6 cycles after the step. Write 2 to 0xF02 -> BTN_EDGE = 0.
- PRESCALE = 3, TIMER_CMP = 2 -> TIMER_CNT sequence 0,1,2,0 changing every 3 cycles; STATUS = 1 after the 3rd tick. Write 1 to 0xF05 in that tick cycle -> STATUS remains 1. Write 1 again in a non-tick cycle -> STATUS = 0.
- Write 16'h0005 to TIMER_CNT in a tick cycle -> TIMER_CNT = 5 on the next read, not 6.
- Assert RST mid-count with a simultaneous write of 16'h00FF to 0xF00 -> every register at its reset value, DISP_NUM = 0.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped I/O responder: window base,
// register offsets and status bit positions.
package mmio_pkg;
    localparam logic [11:0] IO_BASE_DEFAULT = 12'hF00;

    localparam logic [3:0] OFF_DISP      = 4'h0;
    localparam logic [3:0] OFF_BTN_STATE = 4'h1;
    localparam logic [3:0] OFF_BTN_EDGE  = 4'h2;
    localparam logic [3:0] OFF_TIMER_CNT = 4'h3;
    localparam logic [3:0] OFF_TIMER_CMP = 4'h4;
    localparam logic [3:0] OFF_STATUS    = 4'h5;

    localparam int STATUS_MATCH_BIT = 0;
endpackage

// File: rtl/btn_debounce.sv
// One-bit button conditioner: two-flop synchronizer followed by a stability
// counter; RISE pulses in the same cycle the accepted level goes 0->1.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic CLK,
    input  logic RST,
    input  logic IN,
    output logic STATE,
    output logic RISE
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          state_reg;
    logic [CW-1:0] cnt_reg;
    logic          accept;

    assign accept = (sync2_reg != state_reg) && (cnt_reg == CNT_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            state_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= IN;
            sync2_reg <= sync1_reg;
            if (sync2_reg == state_reg) begin
                cnt_reg <= '0;
            end else if (accept) begin
                state_reg <= sync2_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign STATE = state_reg;
    assign RISE  = accept & sync2_reg;
endmodule

// File: rtl/mmio_responder.sv
// Sits between core and RAM: RAM window passes through, the 16-register
// I/O window holds display, debounced buttons and a prescaled timer.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter int                ADDR_W          = 12,
    parameter int                DATA_W          = 16,
    parameter logic [ADDR_W-1:0] IO_BASE         = IO_BASE_DEFAULT,
    parameter int                NBTN            = 4,
    parameter int                DEBOUNCE_CYCLES = 50000,
    parameter int                PRESCALE        = 50000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] CORE_ADDR,
    input  logic              CORE_WREN,
    input  logic [DATA_W-1:0] CORE_DATA,
    output logic [DATA_W-1:0] CORE_Q,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic              RAM_WREN,
    output logic [DATA_W-1:0] RAM_DATA,
    input  logic [DATA_W-1:0] RAM_Q,
    input  logic [NBTN-1:0]   BTN,
    output logic [15:0]       DISP_NUM
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic              io_sel;
    logic [3:0]        offset;
    logic [DATA_W-1:0] io_rdata;
    logic [NBTN-1:0]   btn_state;
    logic [NBTN-1:0]   btn_rise;
    logic [NBTN-1:0]   edge_clr;

    logic [15:0]       disp_reg;
    logic [NBTN-1:0]   edge_reg;
    logic [15:0]       tcnt_reg;
    logic [15:0]       tcmp_reg;
    logic              status_reg;
    logic [PW-1:0]     presc_reg;

    logic tick, wr_io, wr_disp, wr_edge, wr_cnt, wr_cmp, wr_status, match_set;

    assign io_sel = (CORE_ADDR[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4]);
    assign offset = CORE_ADDR[3:0];

    assign RAM_ADDR = CORE_ADDR;
    assign RAM_DATA = CORE_DATA;
    assign RAM_WREN = CORE_WREN & ~io_sel;
    assign CORE_Q   = io_sel ? io_rdata : RAM_Q;
    assign DISP_NUM = disp_reg;

    generate
        for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_db (
                .CLK  (CLK),
                .RST  (RST),
                .IN   (BTN[gi]),
                .STATE(btn_state[gi]),
                .RISE (btn_rise[gi])
            );
        end
    endgenerate

    always_comb begin
        io_rdata = '0;
        case (offset)
            OFF_DISP:      io_rdata = disp_reg;
            OFF_BTN_STATE: io_rdata[NBTN-1:0] = btn_state;
            OFF_BTN_EDGE:  io_rdata[NBTN-1:0] = edge_reg;
            OFF_TIMER_CNT: io_rdata = tcnt_reg;
            OFF_TIMER_CMP: io_rdata = tcmp_reg;
            OFF_STATUS:    io_rdata[STATUS_MATCH_BIT] = status_reg;
            default:       io_rdata = '0;
        endcase
    end

    assign wr_io     = CORE_WREN & io_sel;
    assign wr_disp   = wr_io && (offset == OFF_DISP);
    assign wr_edge   = wr_io && (offset == OFF_BTN_EDGE);
    assign wr_cnt    = wr_io && (offset == OFF_TIMER_CNT);
    assign wr_cmp    = wr_io && (offset == OFF_TIMER_CMP);
    assign wr_status = wr_io && (offset == OFF_STATUS);

    assign tick      = (presc_reg == PRESC_LAST);
    assign edge_clr  = wr_edge ? CORE_DATA[NBTN-1:0] : '0;
    // A core write to the counter pre-empts match evaluation in that cycle.
    assign match_set = tick && !wr_cnt && (tcnt_reg == tcmp_reg);

    always_ff @(posedge CLK) begin
        if (RST) begin
            disp_reg   <= '0;
            edge_reg   <= '0;
            tcnt_reg   <= '0;
            tcmp_reg   <= 16'hFFFF;
            status_reg <= 1'b0;
            presc_reg  <= '0;
        end else begin
            presc_reg <= tick ? '0 : presc_reg + 1'b1;
            if (wr_disp) disp_reg <= CORE_DATA;
            edge_reg <= (edge_reg & ~edge_clr) | btn_rise;
            if (wr_cnt) begin
                tcnt_reg <= CORE_DATA;
            end else if (tick) begin
                tcnt_reg <= (tcnt_reg == tcmp_reg) ? 16'h0000 : tcnt_reg + 16'h0001;
            end
            if (wr_cmp) tcmp_reg <= CORE_DATA;
            status_reg <= (status_reg & ~(wr_status & CORE_DATA[STATUS_MATCH_BIT])) | match_set;
        end
    end
endmodule

// File: tb/tb_mmio_responder.sv
// Randomized bench for mmio_responder: a cycle-level reference model feeds a
// scoreboard queue that a separate monitor drains and compares.
module tb_mmio_responder;
    localparam int D = 4;
    localparam int P = 3;

    logic        CLK;
    logic        RST;
    logic [11:0] CORE_ADDR;
    logic        CORE_WREN;
    logic [15:0] CORE_DATA;
    logic [15:0] CORE_Q;
    logic [11:0] RAM_ADDR;
    logic        RAM_WREN;
    logic [15:0] RAM_DATA;
    logic [15:0] RAM_Q;
    logic [3:0]  BTN;
    logic [15:0] DISP_NUM;

    mmio_responder #(
        .ADDR_W(12), .DATA_W(16), .IO_BASE(12'hF00), .NBTN(4),
        .DEBOUNCE_CYCLES(D), .PRESCALE(P)
    ) dut (
        .CLK(CLK), .RST(RST), .CORE_ADDR(CORE_ADDR), .CORE_WREN(CORE_WREN),
        .CORE_DATA(CORE_DATA), .CORE_Q(CORE_Q), .RAM_ADDR(RAM_ADDR),
        .RAM_WREN(RAM_WREN), .RAM_DATA(RAM_DATA), .RAM_Q(RAM_Q),
        .BTN(BTN), .DISP_NUM(DISP_NUM)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // RAM clocked on the falling edge, read-before-write
    logic [15:0] ram [0:4095];
    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 16'h0000;
    end
    always @(negedge CLK) begin
        if (RAM_WREN) ram[RAM_ADDR] <= RAM_DATA;
        RAM_Q <= ram[RAM_ADDR];
    end

    typedef struct {
        logic [11:0] addr;
        logic [15:0] q;
        logic [15:0] disp;
        logic        wren;
        bit          chk;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    // reference model state
    logic [15:0] m_mem [0:4095];
    logic [15:0] m_disp, m_tcnt, m_tcmp;
    logic [3:0]  m_bstate, m_bedge;
    logic        m_status;
    int          m_cyc;
    logic [3:0]  hist[$];
    bit          model_valid = 0;

    function automatic logic [15:0] model_read(input logic [3:0] off);
        case (off)
            4'h0: return m_disp;
            4'h1: return {12'h000, m_bstate};
            4'h2: return {12'h000, m_bedge};
            4'h3: return m_tcnt;
            4'h4: return m_tcmp;
            4'h5: return {15'h0000, m_status};
            default: return 16'h0000;
        endcase
    endfunction

    function automatic bit tick_now();
        return (m_cyc % P) == P - 1;
    endfunction

    task automatic model_reset();
        m_disp = 16'h0; m_bstate = 4'h0; m_bedge = 4'h0;
        m_tcnt = 16'h0; m_tcmp = 16'hFFFF; m_status = 1'b0; m_cyc = 0;
        hist.delete();
        repeat (D + 2) hist.push_back(4'h0);
    endtask

    // Advance the model across one rising edge with the inputs of that cycle.
    task automatic model_update(input logic [11:0] a, input logic w, input logic [15:0] d,
                                input logic [3:0] b, input logic r);
        bit io, tick, set, same;
        logic [3:0] rise, clr_edge, lvl;
        io = (a[11:4] == 8'hF0);
        if (w && !io) m_mem[a] = d;
        if (r) begin
            model_reset();
            model_valid = 1;
            return;
        end
        tick = tick_now();
        hist.push_back(b);
        while (hist.size() > D + 2) void'(hist.pop_front());
        // a level is accepted once the D synchronized samples all agree on it
        rise = 4'h0;
        for (int i = 0; i < 4; i++) begin
            lvl[i] = hist[hist.size() - 3][i];
            same = 1;
            for (int k = 2; k <= D + 1; k++)
                if (hist[hist.size() - 1 - k][i] != lvl[i]) same = 0;
            if (same && lvl[i] != m_bstate[i]) begin
                m_bstate[i] = lvl[i];
                rise[i] = lvl[i];
            end
        end
        clr_edge = (w && io && a[3:0] == 4'h2) ? d[3:0] : 4'h0;
        m_bedge = (m_bedge & ~clr_edge) | rise;
        set = 0;
        if (w && io && a[3:0] == 4'h3) m_tcnt = d;
        else if (tick) begin
            if (m_tcnt == m_tcmp) begin
                m_tcnt = 16'h0;
                set = 1;
            end else m_tcnt = m_tcnt + 16'h1;
        end
        if (w && io && a[3:0] == 4'h4) m_tcmp = d;
        if (w && io && a[3:0] == 4'h0) m_disp = d;
        m_status = (m_status & !(w && io && a[3:0] == 4'h5 && d[0])) | set;
        m_cyc++;
    endtask

    // Called just after a rising edge: drive one cycle and record expectations.
    task automatic step(input logic [11:0] a, input logic w, input logic [15:0] d,
                        input logic [3:0] b, input logic r);
        exp_t e;
        bit io;
        CORE_ADDR = a; CORE_WREN = w; CORE_DATA = d; BTN = b; RST = r;
        io = (a[11:4] == 8'hF0);
        e.addr = a;
        e.q    = io ? model_read(a[3:0]) : m_mem[a];
        e.disp = m_disp;
        e.wren = w && !io;
        e.chk  = model_valid;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        model_update(a, w, d, b, r);
    endtask

    task automatic check16(input string name, input logic [11:0] a,
                           input logic [15:0] act, input logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s addr=%h got=%h want=%h", name, a, act, want);
        end
    endtask

    // monitor: samples well after the falling edge, away from the rising edge
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk) begin
                    txn++;
                    check16("core_q", e.addr, CORE_Q, e.q);
                    check16("disp_num", e.addr, DISP_NUM, e.disp);
                    check16("ram_wren", e.addr, {15'h0, RAM_WREN}, {15'h0, e.wren});
                    $display("txn %0d addr=%h q=%h disp=%h wren=%b", txn, e.addr, CORE_Q,
                             DISP_NUM, RAM_WREN);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  btn;
        logic [11:0] a;
        logic [15:0] d;
        logic        w, r;
        int          n;
        for (int i = 0; i < 4096; i++) m_mem[i] = 16'h0;
        model_reset();
        CORE_ADDR = 12'h0; CORE_WREN = 1'b0; CORE_DATA = 16'h0; BTN = 4'h0; RST = 1'b1;
        btn = 4'h0;
        @(posedge CLK);
        #1;
        step(12'h000, 0, 16'h0, btn, 1);
        step(12'h000, 0, 16'h0, btn, 1);
        for (int i = 0; i < 8; i++) step(12'hF00 + 12'(i), 0, 16'h0, btn, 0);

        step(12'hF00, 1, 16'h1234, btn, 0);
        step(12'hF00, 0, 16'h0, btn, 0);
        step(12'h010, 1, 16'hBEEF, btn, 0);
        step(12'h010, 0, 16'h0, btn, 0);
        step(12'hF0A, 0, 16'h0, btn, 0);
        step(12'hF0A, 1, 16'h5555, btn, 0);
        step(12'hF0A, 0, 16'h0, btn, 0);

        // glitch shorter than the debounce window, then a clean press
        repeat (3) step(12'hF01, 0, 16'h0, 4'h2, 0);
        repeat (10) step(12'hF01, 0, 16'h0, 4'h0, 0);
        btn = 4'h2;
        for (int i = 0; i < 12; i++) step((i % 2 == 0) ? 12'hF01 : 12'hF02, 0, 16'h0, btn, 0);
        step(12'hF02, 1, 16'h0002, btn, 0);
        step(12'hF02, 0, 16'h0, btn, 0);

        step(12'hF04, 1, 16'h0002, btn, 0);
        step(12'hF03, 1, 16'h0000, btn, 0);
        repeat (12) step(12'hF03, 0, 16'h0, btn, 0);
        n = 0;
        while (!(tick_now() && m_tcnt == m_tcmp) && n < 40) begin
            step(12'hF05, 0, 16'h0, btn, 0);
            n++;
        end
        step(12'hF05, 1, 16'h0001, btn, 0);
        step(12'hF05, 0, 16'h0, btn, 0);
        if (tick_now()) step(12'hF05, 0, 16'h0, btn, 0);
        step(12'hF05, 1, 16'h0001, btn, 0);
        step(12'hF05, 0, 16'h0, btn, 0);
        n = 0;
        while (!tick_now() && n < 10) begin
            step(12'hF03, 0, 16'h0, btn, 0);
            n++;
        end
        step(12'hF03, 1, 16'h0005, btn, 0);
        step(12'hF03, 0, 16'h0, btn, 0);

        step(12'hF00, 1, 16'h00FF, btn, 1);
        for (int i = 0; i < 6; i++) step(12'hF00 + 12'(i), 0, 16'h0, btn, 0);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) < 6) a = 12'hF00 | 12'($urandom_range(0, 15));
            else a = 12'($urandom_range(0, 31));
            w = ($urandom_range(0, 9) < 3);
            d = 16'($urandom);
            if (a == 12'hF04) d = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 7) == 0) btn = 4'($urandom);
            r = ($urandom_range(0, 199) == 0);
            step(a, w, d, btn, r);
        end

        n = 0;
        while (sb.size() > 0 && n < 5) begin
            @(posedge CLK);
            n++;
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
